// File: rtl/alu_result_stage.sv
// alu_result_stage: lane-merging 2-deep result FIFO with delivered-result counter.
// Optional macro ALU_RESULT_FLAGS_EN stores zero/neg flags per entry at push time.
module alu_result_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_res,
    input  logic [1:0]  in_be,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_zero,
    output logic        out_neg,
    output logic [7:0]  out_count
);
`ifdef ALU_RESULT_FLAGS_EN
    localparam int EW = 18;
`else
    localparam int EW = 16;
`endif
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_nxt;
    logic [15:0] shadow, merged;
    logic [EW-1:0] e0, e1, entry;
    logic push, pop, head_wr, tail_wr;
    always_comb begin
        in_ready  = state != FULL;
        out_valid = state != EMPTY;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        merged    = {in_be[1] ? in_res[15:8] : shadow[15:8], in_be[0] ? in_res[7:0] : shadow[7:0]};
`ifdef ALU_RESULT_FLAGS_EN
        entry     = {merged == 16'h0000, merged[15], merged};
`else
        entry     = merged;
`endif
        head_wr   = push && (state == EMPTY || pop);
        tail_wr   = push && state == ONE && !pop;
        state_nxt = (push && !pop) ? (state == EMPTY ? ONE : FULL) :
                    (pop && !push) ? (state == FULL ? ONE : EMPTY) : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            shadow    <= '0;
            e0        <= '0;
            e1        <= '0;
            out_count <= '0;
        end else begin
            state     <= state_nxt;
            shadow    <= push ? merged : shadow;
            e0        <= head_wr ? entry : (pop ? e1 : e0);
            e1        <= tail_wr ? entry : e1;
            out_count <= out_count + {7'd0, pop};
        end
    end
    assign out_data = out_valid ? e0[15:0] : 16'h0000;
`ifdef ALU_RESULT_FLAGS_EN
    assign out_zero = out_valid && e0[17];
    assign out_neg  = out_valid && e0[16];
`else
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif
endmodule
